// File: rtl/controller_pkg.sv
// Shared types and encodings for the RV32I multicycle control unit.
package controller_pkg;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } ctrl_state_t;

  // RV32I major opcodes handled by this core
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_U_TYPE = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_LUI    = 2'b11;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // Reason the core stopped
  localparam logic [1:0] HALT_NONE    = 2'b00;
  localparam logic [1:0] HALT_ILLEGAL = 2'b01;
  localparam logic [1:0] HALT_TIMEOUT = 2'b10;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_LOAD)   || (op == OP_STORE)  || (op == OP_R_TYPE) ||
           (op == OP_I_TYPE) || (op == OP_U_TYPE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Free-running retired-instruction counter; wraps silently at 2^W.
module retire_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  // Count one per retire strobe, clear on reset
  always_ff @(posedge clk) begin
    if (srst)
      count_reg <= '0;
    else if (inc)
      count_reg <= count_reg + 1'b1;
  end

  assign count = count_reg;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/write-back with
// memory handshake, sticky halt on illegal opcode or memory timeout, and an
// instruction-retired counter.
module multicycle_controller
  import controller_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode,
  input  logic             MemReady,
  output logic [1:0]       ALUOp,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             Branch,
  output logic             Halt,
  output logic [1:0]       HaltCause,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] Instret
);

  // A zero timeout still needs a legal one-bit counter even though it is unused
  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  ctrl_state_t       state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg;
  logic [WAIT_W:0]   wait_inc;
  logic              halt_reg;
  logic [1:0]        cause_reg, cause_next;
  logic              retire;
  logic              timeout_hit;

  // Timeout fires on the wait cycle that would bring the counter to the limit;
  // a MemReady in that same cycle takes priority.
  assign wait_inc    = {1'b0, wait_reg} + 1'b1;
  assign timeout_hit = (MEM_TIMEOUT != 0) && !MemReady &&
                       (wait_inc == (WAIT_W + 1)'(MEM_TIMEOUT));

  // Next-state and control strobes; everything forced low while reset is high
  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    retire     = 1'b0;
    ALUOp      = ALUOP_ADD;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    Branch     = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_RESET: state_next = S_FETCH;
        S_FETCH: begin
          MemRead = 1'b1;
          if (MemReady) begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            ALUSrcB    = SRCB_FOUR;
            state_next = S_DECODE;
          end else if (timeout_hit) begin
            state_next = S_HALT;
            cause_next = HALT_TIMEOUT;
          end
        end
        S_DECODE: begin
          ALUSrcB = SRCB_IMM;
          if (is_legal(Opcode)) begin
            state_next = S_EXEC;
          end else begin
            state_next = S_HALT;
            cause_next = HALT_ILLEGAL;
          end
        end
        S_EXEC: begin
          case (Opcode)
            OP_LOAD, OP_STORE: begin
              ALUSrcA    = 1'b1;
              ALUSrcB    = SRCB_IMM;
              state_next = S_MEM;
            end
            OP_R_TYPE: begin
              ALUSrcA    = 1'b1;
              ALUOp      = ALUOP_FUNCT;
              state_next = S_WB;
            end
            OP_I_TYPE: begin
              ALUSrcA    = 1'b1;
              ALUSrcB    = SRCB_IMM;
              ALUOp      = ALUOP_FUNCT;
              state_next = S_WB;
            end
            OP_U_TYPE: begin
              ALUSrcB    = SRCB_IMM;
              ALUOp      = ALUOP_LUI;
              state_next = S_WB;
            end
            OP_BRANCH: begin
              ALUSrcA    = 1'b1;
              ALUOp      = ALUOP_BRANCH;
              Branch     = 1'b1;
              retire     = 1'b1;
              state_next = S_FETCH;
            end
            default: begin
              // IR is not expected to change after DECODE; treat it as illegal
              state_next = S_HALT;
              cause_next = HALT_ILLEGAL;
            end
          endcase
        end
        S_MEM: begin
          IorD = 1'b1;
          if (Opcode == OP_STORE)
            MemWrite = 1'b1;
          else
            MemRead = 1'b1;
          if (MemReady) begin
            if (Opcode == OP_STORE) begin
              retire     = 1'b1;
              state_next = S_FETCH;
            end else begin
              state_next = S_WB;
            end
          end else if (timeout_hit) begin
            state_next = S_HALT;
            cause_next = HALT_TIMEOUT;
          end
        end
        S_WB: begin
          RegWrite   = 1'b1;
          MemToReg   = (Opcode == OP_LOAD);
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        S_HALT: state_next = S_HALT;
        default: state_next = S_RESET;
      endcase
    end
  end

  // State, halt status and memory wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_RESET;
      halt_reg  <= 1'b0;
      cause_reg <= HALT_NONE;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      halt_reg  <= (state_next == S_HALT);
      cause_reg <= cause_next;
      if (state_next != state_reg)
        wait_reg <= '0;
      else if (((state_reg == S_FETCH) || (state_reg == S_MEM)) && !MemReady)
        wait_reg <= wait_inc[WAIT_W-1:0];
    end
  end

  retire_counter #(.W(CNT_W)) u_instret (
    .clk   (clk),
    .srst  (reset),
    .inc   (retire),
    .count (Instret)
  );

  assign State     = state_reg;
  assign Halt      = halt_reg;
  assign HaltCause = cause_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the driver pushes one expected
// output record per cycle, the monitor pops and compares on the falling edge.
module tb_multicycle_controller;
  import controller_pkg::*;

  localparam int CW = 4;
  localparam int TO = 4;

  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_BAD = 7'b1111111;

  // {ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite, PCWrite, MemToReg, RegWrite, Branch}
  localparam logic [12:0] E0    = 13'b00_0_00_0_0_0_0_0_0_0_0;
  localparam logic [12:0] E_FW  = 13'b00_0_00_0_1_0_0_0_0_0_0;
  localparam logic [12:0] E_FG  = 13'b00_0_01_0_1_0_1_1_0_0_0;
  localparam logic [12:0] E_DEC = 13'b00_0_10_0_0_0_0_0_0_0_0;
  localparam logic [12:0] E_LS  = 13'b00_1_10_0_0_0_0_0_0_0_0;
  localparam logic [12:0] E_R   = 13'b10_1_00_0_0_0_0_0_0_0_0;
  localparam logic [12:0] E_I   = 13'b10_1_10_0_0_0_0_0_0_0_0;
  localparam logic [12:0] E_LUI = 13'b11_0_10_0_0_0_0_0_0_0_0;
  localparam logic [12:0] E_BR  = 13'b01_1_00_0_0_0_0_0_0_0_1;
  localparam logic [12:0] E_MLD = 13'b00_0_00_1_1_0_0_0_0_0_0;
  localparam logic [12:0] E_MST = 13'b00_0_00_1_0_1_0_0_0_0_0;
  localparam logic [12:0] E_WLD = 13'b00_0_00_0_0_0_0_0_1_1_0;
  localparam logic [12:0] E_WAL = 13'b00_0_00_0_0_0_0_0_0_1_0;

  logic          clk;
  logic          reset;
  logic [6:0]    Opcode;
  logic          MemReady;
  logic [1:0]    ALUOp;
  logic          ALUSrcA;
  logic [1:0]    ALUSrcB;
  logic          IorD, MemRead, MemWrite, IRWrite, PCWrite, MemToReg, RegWrite, Branch;
  logic          Halt;
  logic [1:0]    HaltCause;
  logic [2:0]    State;
  logic [CW-1:0] Instret;
  logic [12:0]   en_act;

  typedef struct {
    logic [2:0]    st;
    logic [12:0]   en;
    logic          halt;
    logic [1:0]    cause;
    logic [CW-1:0] ir;
    int            id;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   vectors = 0;
  int   miscompares = 0;
  int   nvec = 0;

  multicycle_controller #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .Opcode    (Opcode),
    .MemReady  (MemReady),
    .ALUOp     (ALUOp),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .IorD      (IorD),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .MemToReg  (MemToReg),
    .RegWrite  (RegWrite),
    .Branch    (Branch),
    .Halt      (Halt),
    .HaltCause (HaltCause),
    .State     (State),
    .Instret   (Instret)
  );

  assign en_act = {ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite,
                   IRWrite, PCWrite, MemToReg, RegWrite, Branch};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs just after the rising edge and queue the outputs expected in that cycle
  task automatic vec(input logic r, input logic [6:0] op, input logic mr,
                     input ctrl_state_t st, input logic [12:0] en,
                     input logic h, input logic [1:0] c, input int ir);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = r;
    Opcode   = op;
    MemReady = mr;
    e.st     = st;
    e.en     = en;
    e.halt   = h;
    e.cause  = c;
    e.ir     = CW'(ir);
    e.id     = nvec;
    nvec     = nvec + 1;
    sb.push_back(e);
  endtask

  // One ALU-class instruction with memory always ready: FETCH, DECODE, EXEC, WB
  task automatic alu_instr(input logic [6:0] op, input logic [12:0] ex_en, input int ir);
    vec(1'b0, op, 1'b1, S_FETCH,  E_FG,  1'b0, 2'b00, ir);
    vec(1'b0, op, 1'b1, S_DECODE, E_DEC, 1'b0, 2'b00, ir);
    vec(1'b0, op, 1'b1, S_EXEC,   ex_en, 1'b0, 2'b00, ir);
    vec(1'b0, op, 1'b1, S_WB,     E_WAL, 1'b0, 2'b00, ir);
  endtask

  // Monitor: compare every queued record against the DUT mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m = sb.pop_front();
      vectors = vectors + 1;
      if (State !== m.st || en_act !== m.en || Halt !== m.halt ||
          HaltCause !== m.cause || Instret !== m.ir) begin
        miscompares = miscompares + 1;
        $display("FAIL vec%0d: got state=%0d en=%b halt=%b cause=%b instret=%0d, want state=%0d en=%b halt=%b cause=%b instret=%0d",
                 m.id, State, en_act, Halt, HaltCause, Instret,
                 m.st, m.en, m.halt, m.cause, m.ir);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    Opcode   = 7'd0;
    MemReady = 1'b1;

    // Reset held three cycles, then released
    repeat (3) vec(1'b1, 7'd0, 1'b1, S_RESET, E0, 1'b0, 2'b00, 0);
    vec(1'b0, OPC_R, 1'b1, S_RESET, E0, 1'b0, 2'b00, 0);

    // Three back-to-back ALU instructions
    alu_instr(OPC_R,   E_R,   0);
    alu_instr(OPC_I,   E_I,   1);
    alu_instr(OPC_LUI, E_LUI, 2);

    // LOAD with two wait cycles in FETCH and two in MEM
    vec(1'b0, OPC_LD, 1'b0, S_FETCH,  E_FW,  1'b0, 2'b00, 3);
    vec(1'b0, OPC_LD, 1'b0, S_FETCH,  E_FW,  1'b0, 2'b00, 3);
    vec(1'b0, OPC_LD, 1'b1, S_FETCH,  E_FG,  1'b0, 2'b00, 3);
    vec(1'b0, OPC_LD, 1'b1, S_DECODE, E_DEC, 1'b0, 2'b00, 3);
    vec(1'b0, OPC_LD, 1'b1, S_EXEC,   E_LS,  1'b0, 2'b00, 3);
    vec(1'b0, OPC_LD, 1'b0, S_MEM,    E_MLD, 1'b0, 2'b00, 3);
    vec(1'b0, OPC_LD, 1'b0, S_MEM,    E_MLD, 1'b0, 2'b00, 3);
    vec(1'b0, OPC_LD, 1'b1, S_MEM,    E_MLD, 1'b0, 2'b00, 3);
    vec(1'b0, OPC_LD, 1'b1, S_WB,     E_WLD, 1'b0, 2'b00, 3);

    // STORE with memory stuck: four MemWrite cycles, then timeout halt
    vec(1'b0, OPC_ST, 1'b1, S_FETCH,  E_FG,  1'b0, 2'b00, 4);
    vec(1'b0, OPC_ST, 1'b1, S_DECODE, E_DEC, 1'b0, 2'b00, 4);
    vec(1'b0, OPC_ST, 1'b1, S_EXEC,   E_LS,  1'b0, 2'b00, 4);
    repeat (4) vec(1'b0, OPC_ST, 1'b0, S_MEM,  E_MST, 1'b0, 2'b00, 4);
    repeat (3) vec(1'b0, OPC_ST, 1'b1, S_HALT, E0,    1'b1, 2'b10, 4);
    vec(1'b1, OPC_ST, 1'b1, S_HALT,  E0, 1'b1, 2'b10, 4);
    vec(1'b0, OPC_ST, 1'b1, S_RESET, E0, 1'b0, 2'b00, 0);

    // STORE whose MemReady arrives on the fourth wait cycle
    vec(1'b0, OPC_ST, 1'b1, S_FETCH,  E_FG,  1'b0, 2'b00, 0);
    vec(1'b0, OPC_ST, 1'b1, S_DECODE, E_DEC, 1'b0, 2'b00, 0);
    vec(1'b0, OPC_ST, 1'b1, S_EXEC,   E_LS,  1'b0, 2'b00, 0);
    repeat (3) vec(1'b0, OPC_ST, 1'b0, S_MEM, E_MST, 1'b0, 2'b00, 0);
    vec(1'b0, OPC_ST, 1'b1, S_MEM, E_MST, 1'b0, 2'b00, 0);

    // Illegal opcode: halt with cause 01 and stay there for 20 cycles
    vec(1'b0, OPC_BAD, 1'b1, S_FETCH,  E_FG,  1'b0, 2'b00, 1);
    vec(1'b0, OPC_BAD, 1'b1, S_DECODE, E_DEC, 1'b0, 2'b00, 1);
    for (int i = 0; i < 20; i++)
      vec(1'b0, OPC_BAD, 1'(i % 2), S_HALT, E0, 1'b1, 2'b01, 1);
    vec(1'b1, OPC_BR, 1'b1, S_HALT,  E0, 1'b1, 2'b01, 1);
    vec(1'b0, OPC_BR, 1'b1, S_RESET, E0, 1'b0, 2'b00, 0);

    // Seventeen branches: the 4-bit counter wraps 15 -> 0 and then reads 1
    for (int k = 0; k < 17; k++) begin
      vec(1'b0, OPC_BR, 1'b1, S_FETCH,  E_FG,  1'b0, 2'b00, k);
      vec(1'b0, OPC_BR, 1'b1, S_DECODE, E_DEC, 1'b0, 2'b00, k);
      vec(1'b0, OPC_BR, 1'b1, S_EXEC,   E_BR,  1'b0, 2'b00, k);
    end

    // Reset arriving mid-MEM of a STORE: strobes drop, nothing retires
    vec(1'b0, OPC_ST, 1'b1, S_FETCH,  E_FG,  1'b0, 2'b00, 1);
    vec(1'b0, OPC_ST, 1'b1, S_DECODE, E_DEC, 1'b0, 2'b00, 1);
    vec(1'b0, OPC_ST, 1'b1, S_EXEC,   E_LS,  1'b0, 2'b00, 1);
    vec(1'b0, OPC_ST, 1'b0, S_MEM,    E_MST, 1'b0, 2'b00, 1);
    vec(1'b1, OPC_ST, 1'b1, S_MEM,    E0,    1'b0, 2'b00, 1);
    vec(1'b0, OPC_ST, 1'b1, S_RESET,  E0,    1'b0, 2'b00, 0);
    vec(1'b0, OPC_ST, 1'b1, S_FETCH,  E_FG,  1'b0, 2'b00, 0);

    @(negedge clk);
    #1;
    vectors = vectors + 1;
    if (sb.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL drain: %0d records left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle control unit for the RV32I core: a Moore/Mealy FSM that sequences each instruction through fetch, decode, execute, memory and write-back. It replaces single-cycle opcode decoding and drives the shared-memory multicycle datapath. It adds three things:
- a ready/valid-style wait on memory,
- sticky halt on illegal opcodes or memory timeout,
- a retired-instruction counter.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter `Instret`.
- MEM_TIMEOUT, 16, max cycles spent waiting on `MemReady` in one memory state before halting; 0 disables the timeout.

Ports:
- clk  input  1  system clock; everything updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Opcode  input  7  opcode field from the datapath IR; valid from DECODE onward.
- MemReady  input  1  memory completed the current read/write this cycle.
- ALUOp  output  2  00 add (LOAD/STORE/PC arithmetic), 01 BRANCH, 10 R_TYPE/I_TYPE, 11 LUI.
- ALUSrcA  output  1  0 PC, 1 ReadData1.
- ALUSrcB  output  2  00 ReadData2, 01 constant 4, 10 immediate.
- IorD  output  1  memory address source: 0 PC, 1 ALUOut.
- MemRead, MemWrite  output  1 each  memory strobes.
- IRWrite, PCWrite  output  1 each  IR and PC load enables.
- MemToReg  output  1  write-back source: 0 ALUOut, 1 MDR.
- RegWrite  output  1  register file write enable.
- Branch  output  1  datapath may load PC from ALUOut if the comparison holds.
- Halt  output  1  core stopped, sticky until reset.
- HaltCause  output  2  00 none, 01 illegal opcode, 10 memory timeout.
- State  output  3  current FSM state, for debug.
- Instret  output  CNT_W  count of retired instructions.

## Operation
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, HALT.
- RESET: all outputs 0. Unconditionally goes to FETCH.
- FETCH:
  - MemRead=1, IorD=0.
  - Waits while MemReady=0.
  - On MemReady=1, in the same cycle: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00 (PC+4). Then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target into ALUOut).
  - Legal opcodes: LOAD 0000011, STORE 0100011, R_TYPE 0110011, I_TYPE 0010011, LUI 0110111, BRANCH 1100011. Legal → EXEC.
  - Anything else → HALT with HaltCause=01.
- EXEC:
  - LOAD/STORE: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → MEM.
  - R_TYPE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → WB.
  - I_TYPE: ALUSrcA=1, ALUSrcB=10, ALUOp=10 → WB.
  - LUI: ALUSrcB=10, ALUOp=11 → WB.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1 → FETCH; the instruction retires here.
- MEM: IorD=1.
  - LOAD: MemRead=1; on MemReady → WB.
  - STORE: MemWrite=1; on MemReady → FETCH and retire.
  - Strobes stay asserted until MemReady.
- WB: RegWrite=1, MemToReg=1 only for LOAD. → FETCH and retire.
- HALT:
  - All strobes and enables are 0; Halt=1; HaltCause is held.
  - Only reset leaves HALT.
- Timeout:
  - A wait counter, width clog2(MEM_TIMEOUT+1), increments each cycle in FETCH or MEM while MemReady=0.
  - It clears on state change.
  - When it reaches MEM_TIMEOUT with MemReady still 0 → HALT, HaltCause=10.
  - If MemReady=1 in the same cycle the counter reaches MEM_TIMEOUT, the access completes normally; MemReady wins.
- Instret: increments by 1 on each retire and wraps modulo 2^CNT_W with no flag.
- Outputs:
  - Enables are combinational from state, Opcode and MemReady.
  - Halt, HaltCause, State and Instret are registered.

## Timing
- Reset takes effect on the next clock edge. One cycle after reset deasserts, the FSM is in FETCH.
  - Reset values: State=RESET, Instret=0, Halt=0, HaltCause=00, wait counter 0, all enables 0.
- Latency with MemReady held at 1:
  - R_TYPE, I_TYPE, LUI: 4 cycles.
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each cycle of MemReady=0 adds one cycle of latency.
- Instret becomes visible the cycle after the retiring state.
- Reset asserted mid-MEM: strobes drop in the reset cycle. No retire, no write.

## Structure
- Package `controller_pkg` holds:
  - the state enum `ctrl_state_t`;
  - opcode localparams (LOAD, STORE, R_TYPE, I_TYPE, U_TYPE, BRANCH);
  - ALUOp and ALUSrcB encodings;
  - HaltCause codes.
- Sub-module `retire_counter`: CNT_W-bit counter with synchronous reset and `inc` enable, instantiated for Instret.

## Test plan
- Reset held 3 cycles with MemReady=1 → State=RESET, all outputs 0. After release: FETCH, then IRWrite=PCWrite=1 in the same cycle.
- R_TYPE 0110011 with MemReady=1 → FETCH, DECODE, EXEC (ALUOp=10, ALUSrcB=00), WB (RegWrite=1). Instret=1 after 4 cycles; 3 back-to-back instructions give Instret=3 at cycle 12.
- LOAD with MemReady low for 2 cycles in FETCH and 2 cycles in MEM → MemRead held throughout. WB has MemToReg=1, RegWrite=1. Total 9 cycles.
- Opcode 1111111 in DECODE → HALT next cycle, Halt=1, HaltCause=01, all strobes 0. Stays in HALT for 20 cycles until reset.
- MEM_TIMEOUT=4 with STORE and MemReady stuck at 0 → MemWrite held 4 cycles, then HALT with HaltCause=10 and Instret unchanged.
  - Repeat with MemReady=1 on the 4th wait cycle → store retires normally.
- CNT_W=4 with 16 BRANCH instructions → Instret wraps 15→0. Reset asserted during MEM → next state RESET, Instret=0.
